// File: rtl/mux16_b3.sv
// Registered 8:1 select of WIDTH-bit channels; r updates one clk after set/data are sampled.
// No handshake or backpressure: a new channel is loaded on every edge unless reset is high.
module mux16_b3 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       set,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] sel_dat;

  // Every 3-bit code maps to a channel, so there is no illegal/default output.
  always_comb begin
    sel_dat = '0;
    case (set)
      3'd0: sel_dat = in0;
      3'd1: sel_dat = in1;
      3'd2: sel_dat = in2;
      3'd3: sel_dat = in3;
      3'd4: sel_dat = in4;
      3'd5: sel_dat = in5;
      3'd6: sel_dat = in6;
      3'd7: sel_dat = in7;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r <= '0;
    else       r <= sel_dat;
  end

endmodule

// File: tb/tb_mux16_b3.sv
// Directed and random checks of the registered 8:1 select against a one-cycle-delayed reference mux.
module tb_mux16_b3;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din [8];
  logic [2:0]   set;
  logic [W-1:0] r;
  logic [W-1:0] exp_r;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  mux16_b3 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .in0   (din[0]),
    .in1   (din[1]),
    .in2   (din[2]),
    .in3   (din[3]),
    .in4   (din[4]),
    .in5   (din[5]),
    .in6   (din[6]),
    .in7   (din[7]),
    .set   (set),
    .r     (r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    int unsigned vals [8];
    vals = '{1, 3, 7, 4, 9, 23, 10, 54};

    // Reset with everything at zero
    reset = 1'b1;
    set   = 3'd0;
    for (int i = 0; i < 8; i++) din[i] = '0;
    tick();
    check("reset_cyc1", r, 16'h0000);
    tick();
    check("reset_cyc2", r, 16'h0000);
    reset = 1'b0;
    tick();
    check("post_reset_set0", r, 16'h0000);

    // Walk all eight select codes
    for (int i = 0; i < 8; i++) din[i] = vals[i][W-1:0];
    for (int s = 0; s < 8; s++) begin
      set = s[2:0];
      tick();
      check($sformatf("walk_set%0d", s), r, vals[s][W-1:0]);
    end

    // Hold set=5, change the selected input
    set    = 3'd5;
    din[5] = 16'hFFFF;
    tick();
    check("set5_ffff", r, 16'hFFFF);
    din[0] = 16'hAAAA;
    din[7] = 16'h1234;
    tick();
    check("set5_other_inputs", r, 16'hFFFF);
    din[5] = 16'h0000;
    #3;
    check("hold_between_edges", r, 16'hFFFF);
    din[0] = 16'd1;
    din[7] = 16'd54;
    din[5] = 16'd23;

    // Reset mid-operation, then recover
    set = 3'd7;
    tick();
    check("set7_pre_reset", r, 16'd54);
    reset = 1'b1;
    tick();
    check("reset_mid_op", r, 16'h0000);
    reset = 1'b0;
    tick();
    check("reset_release_set7", r, 16'd54);

    // Select and data change together
    set = 3'd2;
    tick();
    check("set2", r, 16'd7);
    set    = 3'd6;
    din[6] = 16'h8000;
    tick();
    check("set6_same_cycle", r, 16'h8000);

    // Random traffic against a reference mux
    for (int n = 0; n < 1000; n++) begin
      set = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) din[i] = W'($urandom);
      exp_r = din[set];
      tick();
      check($sformatf("random_%0d", n), r, exp_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux16_b3.md
MUX16_B3 -- requirements
Module: mux16_b3

Interface
REQ-001 Parameter: WIDTH, default 16, data width of every data input and of output r.
REQ-002 The block SHALL have exactly one clock and one synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock; all state updates occur on this edge only.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: in0  input  WIDTH  data channel 0.
REQ-006 Port: in1  input  WIDTH  data channel 1.
REQ-007 Port: in2  input  WIDTH  data channel 2.
REQ-008 Port: in3  input  WIDTH  data channel 3.
REQ-009 Port: in4  input  WIDTH  data channel 4.
REQ-010 Port: in5  input  WIDTH  data channel 5.
REQ-011 Port: in6  input  WIDTH  data channel 6.
REQ-012 Port: in7  input  WIDTH  data channel 7.
REQ-013 Port: set  input  3  channel select, unsigned binary 0..7.
REQ-014 Port: r  output  WIDTH  registered selected data.

Function
REQ-015 On each rising clk with reset low, r SHALL load in[set]; set=0 selects in0, 1 selects in1, and so on up to 7 selecting in7.
REQ-016 Latency SHALL be exactly one clock: r reflects set and data inputs sampled at the previous rising edge.
REQ-017 r SHALL hold its value between rising edges regardless of input changes.
REQ-018 All 8 set codes SHALL be valid; there SHALL be no default/illegal code, and no X SHALL propagate for any fully defined set value.
REQ-019 Data SHALL pass bit-exact with no sign extension, truncation or arithmetic.
REQ-020 If set and the selected input change in the same cycle, r SHALL take the new input's value sampled at the edge.
REQ-021 The block SHALL contain no handshake, no state machine and no other storage beyond the WIDTH-bit r register.
REQ-022 Selection logic SHALL be purely combinational ahead of the r register, with no combinational path from any input to r.

Reset
REQ-023 When reset is high at a rising clk, r SHALL become all zeros on that edge, regardless of set or data inputs.
REQ-024 Reset SHALL take priority over the select/load path in the same cycle.
REQ-025 After reset deasserts, the first rising edge with reset low SHALL load in[set] normally.
REQ-026 Reset asserted mid-operation SHALL clear r on the next rising edge with no residual state.
REQ-027 Without reset, r's power-up value is unspecified; the bench SHALL not check r before the first reset.

Verification
REQ-028 Reset high for 2 cycles with all inputs 0, then set=0 -> r=0.
REQ-029 in0..in7 = 1,3,7,4,9,23,10,54; step set 0..7, one value per cycle -> r = 1,3,7,4,9,23,10,54 (decimal), each one cycle after the corresponding set value.
REQ-030 Hold set=5 and change in5 from 23 to 16'hFFFF -> r=16'hFFFF one cycle later; changes on other inputs leave r unchanged.
REQ-031 set=7 with in7=54, then assert reset for one cycle -> r=0 on that edge; deassert reset -> r=54 on the next edge.
REQ-032 Change set from 2 to 6 and in6 from 10 to 16'h8000 in the same cycle -> r=16'h8000 on the next edge.
REQ-033 Random set/in0..in7 for 1000 cycles -> r always equals a one-cycle-delayed reference mux.
